mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-ported RAM between the datapath's instruction-fetch requester and its data load/store requester.
- Sits between the datapath/cache side and the RAM model.
- Owns the grant FSM, hit generation, and starvation prevention.
- Data requests have priority; a bounded counter guarantees that instruction fetch makes forward progress.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while iREN is pending before instruction is force-granted (1..15).
- ADDR_W, 32: address/data word width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  ADDR_W  instruction address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  ADDR_W  data address
- dstore  in  ADDR_W  store data
- ramstate  in  2  ramstate_t: FREE/BUSY/ACCESS/ERROR
- ramload  in  ADDR_W  RAM read data
- ihit  out  1  instruction transaction complete (one cycle)
- dhit  out  1  data transaction complete (one cycle)
- iload  out  ADDR_W  instruction word (ramload passthrough)
- dload  out  ADDR_W  load data (ramload passthrough)
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- perf_icnt  out  32  completed instruction fetches (optional feature)
- perf_dcnt  out  32  completed data accesses (optional feature)
- perf_wait  out  32  cycles any request waited without a hit (optional feature)

Behaviour:
- States: IDLE, IGRANT, DGRANT (arb_state_t). Reset: state=IDLE, starve_cnt=0.
- All outputs are 0 while in IDLE and during reset.
- IDLE:
  - (dREN|dWEN) & ~(iREN & starve_cnt==STARVE_LIMIT) -> DGRANT.
  - else iREN -> IGRANT.
  - else stay.
  - Decision is registered; the RAM is driven starting the cycle after the grant.
- IGRANT: ramREN=1, ramaddr=iaddr, ramWEN=0.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both are asserted).
- Hit: in a granted state with ramstate==ACCESS, the matching hit is asserted combinationally that same cycle; next state=IDLE.
  - Minimum latency is request -> hit in 2 cycles.
- ihit and dhit are never asserted together.
- iload=ramload and dload=ramload; each is valid only while its hit is asserted, and is 0 otherwise.
- ramstate FREE/BUSY: hold the granted state with the RAM signals held stable.
- ramstate ERROR: no hit; return to IDLE; the request re-arbitrates next cycle.
- Request withdrawn while granted (e.g. dREN&dWEN both fall in DGRANT): abort, return to IDLE, no hit.
- starve_cnt:
  - Increments on each dhit while iREN=1, saturating at STARVE_LIMIT.
  - Clears on ihit, or on any IDLE cycle with iREN=0.
- Asynchronous reset mid-transaction: immediately IDLE, RAM enables drop, no hit.

Optional Feature:
- Macro: MEM_ARBITER_PERF_CNT_EN.
- With the macro defined:
  - perf_icnt increments on ihit; perf_dcnt increments on dhit.
  - perf_wait increments each cycle where (iREN|dREN|dWEN) is asserted and neither hit fires.
  - All three reset to 0 and wrap at 2^32.
- Without the macro: the counter logic is absent and the three ports are tied to 0.

Decomposition:
- cpu_types_pkg holds:
  - arb_state_t {IDLE, IGRANT, DGRANT};
  - ramstate_t (existing);
  - localparam ARB_STARVE_W=4.
- Natural sub-module: arb_perf_counter. It is instantiated three times under the macro; each instance is a 32-bit counter with inc input and count output.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0040, RAM gives ACCESS after 1 BUSY cycle -> ramREN=1 and ramaddr=0x40 from cycle 1; ihit pulses in cycle 3 with iload=ramload; state IDLE in cycle 4.
- iREN and dWEN asserted together, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first: ramWEN=1, ramstore=0xDEADBEEF; dhit, then IGRANT; ihit follows; ihit and dhit never coincide.
- STARVE_LIMIT=4 with iREN held and dREN re-asserted after every dhit -> exactly 4 dhits, then an ihit, then starve_cnt=0.
- ramstate=ERROR during DGRANT -> no dhit, state returns to IDLE, ramREN drops for 1 cycle, then the request is re-granted and completes with a dhit.
- nRST asserted mid-IGRANT while BUSY -> ramREN/ihit go to 0 immediately; after release with iREN still high, the fetch restarts from IDLE.
- With MEM_ARBITER_PERF_CNT_EN: 3 fetches at 2 waits each plus 1 load at 3 waits -> perf_icnt=3, perf_dcnt=1, perf_wait matches the counted no-hit request cycles. Without the macro, all counters stay 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the datapath / memory side.
//   arb_state_t  : grant FSM states of mem_arbiter.
//   ramstate_t   : status reported by the RAM model each cycle.
//   ARB_STARVE_W : width of the instruction-starvation counter.
//   PERF_CNT_W   : width of the optional performance counters.
package cpu_types_pkg;

    localparam int unsigned ARB_STARVE_W = 4;
    localparam int unsigned PERF_CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // True when the starvation counter has reached its configured ceiling.
    function automatic logic starve_at_limit(
        input logic [ARB_STARVE_W-1:0] cnt,
        input int unsigned             limit
    );
        return cnt == ARB_STARVE_W'(limit);
    endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// arb_perf_counter: free-running event counter used by mem_arbiter when the
// MEM_ARBITER_PERF_CNT_EN macro is defined; absent from the build otherwise.
// Ports:
//   CLK   : clock
//   nRST  : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current event count, wraps at 2^PERF_CNT_W
`ifdef MEM_ARBITER_PERF_CNT_EN
module arb_perf_counter
    import cpu_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] count
);

    // Wrapping counter, natural modulo-2^N overflow.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc) begin
            count <= count + PERF_CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch
// requester and the data load/store requester. Data has priority; a
// saturating starvation counter force-grants a pending fetch after
// STARVE_LIMIT consecutive data grants.
//
// Optional feature macro: MEM_ARBITER_PERF_CNT_EN (performance counters).
//
// Ports:
//   CLK, nRST          : clock, asynchronous active-low reset
//   iREN, iaddr        : instruction read request (held until ihit), address
//   dREN, dWEN         : data read / write request (held until dhit)
//   daddr, dstore      : data address, store data
//   ramstate, ramload  : RAM status and read data
//   ihit, dhit         : one-cycle completion strobes (never together)
//   iload, dload       : ramload passthrough, nonzero only during the hit
//   ramREN, ramWEN     : RAM enables
//   ramaddr, ramstore  : RAM address and write data
//   perf_icnt/dcnt/wait: completed fetches, completed data accesses,
//                        request cycles without a hit (0 when macro absent)
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  iREN,
    input  logic [ADDR_W-1:0]     iaddr,
    input  logic                  dREN,
    input  logic                  dWEN,
    input  logic [ADDR_W-1:0]     daddr,
    input  logic [ADDR_W-1:0]     dstore,
    input  ramstate_t             ramstate,
    input  logic [ADDR_W-1:0]     ramload,
    output logic                  ihit,
    output logic                  dhit,
    output logic [ADDR_W-1:0]     iload,
    output logic [ADDR_W-1:0]     dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [ADDR_W-1:0]     ramaddr,
    output logic [ADDR_W-1:0]     ramstore,
    output logic [PERF_CNT_W-1:0] perf_icnt,
    output logic [PERF_CNT_W-1:0] perf_dcnt,
    output logic [PERF_CNT_W-1:0] perf_wait
);

    arb_state_t              state;
    logic [ARB_STARVE_W-1:0] starve_cnt;
    logic                    dreq;
    logic                    starved;
    logic                    ram_done;
    logic                    ram_err;

    assign dreq     = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);
    assign ram_err  = (ramstate == ERROR);

    // A pending fetch overrides data priority once the counter is saturated.
    assign starved = iREN & starve_at_limit(starve_cnt, STARVE_LIMIT);

    // Hits are same-cycle: granted state, request still held, RAM reports ACCESS.
    assign ihit = (state == IGRANT) & iREN & ram_done;
    assign dhit = (state == DGRANT) & dreq & ram_done;

    assign iload = ihit ? ramload : '0;
    assign dload = dhit ? ramload : '0;

    // Grant FSM and starvation counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dreq && !starved) begin
                        state <= DGRANT;
                    end else if (iREN) begin
                        state <= IGRANT;
                    end
                end
                // Completion, RAM error or a withdrawn request all end the grant.
                IGRANT: begin
                    if (!iREN || ram_done || ram_err) begin
                        state <= IDLE;
                    end
                end
                DGRANT: begin
                    if (!dreq || ram_done || ram_err) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (ihit || ((state == IDLE) && !iREN)) begin
                starve_cnt <= '0;
            end else if (dhit && iREN && !starve_at_limit(starve_cnt, STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + ARB_STARVE_W'(1);
            end
        end
    end

    // RAM drive decoded from the registered grant; quiet in IDLE.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state)
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            DGRANT: begin
                // Write wins when both data enables are asserted.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARBITER_PERF_CNT_EN
    logic wait_inc;

    // A request is outstanding but nothing completed this cycle.
    assign wait_inc = (iREN | dreq) & ~ihit & ~dhit;

    arb_perf_counter u_perf_icnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (ihit),
        .count (perf_icnt)
    );

    arb_perf_counter u_perf_dcnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (dhit),
        .count (perf_dcnt)
    );

    arb_perf_counter u_perf_wait (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (wait_inc),
        .count (perf_wait)
    );
`else
    assign perf_icnt = '0;
    assign perf_dcnt = '0;
    assign perf_wait = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter plus
// hand-written sequences for starvation and performance counters.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    ramstate_t   ramstate;
    logic [31:0] ramload;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] perf_icnt;
    logic [31:0] perf_dcnt;
    logic [31:0] perf_wait;

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_W       (32)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .ramstate  (ramstate),
        .ramload   (ramload),
        .ihit      (ihit),
        .dhit      (dhit),
        .iload     (iload),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .perf_icnt (perf_icnt),
        .perf_dcnt (perf_dcnt),
        .perf_wait (perf_wait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        ramstate_t   rs;
        logic [31:0] rload;
        logic        e_ihit;
        logic        e_dhit;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic add_vec(
        input logic nrst, input logic iren, input logic [31:0] ia,
        input logic dren, input logic dwen, input logic [31:0] da,
        input logic [31:0] ds, input ramstate_t rs, input logic [31:0] rl,
        input logic e_ihit, input logic e_dhit, input logic e_ren,
        input logic e_wen, input logic [31:0] e_addr, input logic [31:0] e_store
    );
        vec_t v;
        v.nrst = nrst; v.iren = iren; v.iaddr = ia; v.dren = dren; v.dwen = dwen;
        v.daddr = da; v.dstore = ds; v.rs = rs; v.rload = rl;
        v.e_ihit = e_ihit; v.e_dhit = e_dhit; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_addr = e_addr; v.e_store = e_store;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramstate = FREE; ramload = '0;
    endtask

    // One fetch (is_d=0) or load (is_d=1): an IDLE cycle, nbusy BUSY cycles, ACCESS.
    task automatic txn(input bit is_d, input int nbusy, input logic [31:0] addr,
                       input logic [31:0] ld, inout int waits);
        @(negedge CLK);
        if (is_d) begin dREN = 1'b1; daddr = addr; end
        else      begin iREN = 1'b1; iaddr = addr; end
        ramstate = FREE;
        waits++;
        for (int k = 0; k < nbusy; k++) begin
            @(negedge CLK);
            ramstate = BUSY;
            waits++;
        end
        @(negedge CLK);
        ramstate = ACCESS;
        ramload  = ld;
        #2;
        nvec++;
        chk($sformatf("txn%0d ihit", is_d), 32'(ihit), 32'(!is_d));
        chk($sformatf("txn%0d dhit", is_d), 32'(dhit), 32'(is_d));
        chk($sformatf("txn%0d load", is_d), is_d ? dload : iload, ld);
        @(negedge CLK);
        drive_idle();
    endtask

    initial begin
        int  nd;
        int  idx;
        bit  done;
        int  waits;
        logic [31:0] exp_i, exp_d, exp_w;

        nRST = 1'b0;
        drive_idle();

        // Reset: quiet even with requests present.
        add_vec(0,0,32'h0,0,0,32'h0,32'h0,FREE,32'h0,       0,0,0,0,32'h0,32'h0);
        add_vec(0,1,32'h40,0,0,32'h0,32'h0,ACCESS,32'h11,   0,0,0,0,32'h0,32'h0);
        // Fetch: IDLE, IGRANT FREE, BUSY, ACCESS -> ihit, then IDLE.
        add_vec(1,1,32'h40,0,0,32'h0,32'h0,FREE,32'h0,      0,0,0,0,32'h0,32'h0);
        add_vec(1,1,32'h40,0,0,32'h0,32'h0,FREE,32'h0,      0,0,1,0,32'h40,32'h0);
        add_vec(1,1,32'h40,0,0,32'h0,32'h0,BUSY,32'h0,      0,0,1,0,32'h40,32'h0);
        add_vec(1,1,32'h40,0,0,32'h0,32'h0,ACCESS,32'h1234, 1,0,1,0,32'h40,32'h0);
        add_vec(1,0,32'h40,0,0,32'h0,32'h0,FREE,32'h0,      0,0,0,0,32'h0,32'h0);
        // iREN + dWEN together: data write first, then the fetch.
        add_vec(1,1,32'h44,0,1,32'h100,32'hDEADBEEF,FREE,32'h0,    0,0,0,0,32'h0,32'h0);
        add_vec(1,1,32'h44,0,1,32'h100,32'hDEADBEEF,ACCESS,32'h77, 0,1,0,1,32'h100,32'hDEADBEEF);
        add_vec(1,1,32'h44,0,0,32'h100,32'hDEADBEEF,FREE,32'h0,    0,0,0,0,32'h0,32'h0);
        add_vec(1,1,32'h44,0,0,32'h100,32'hDEADBEEF,ACCESS,32'hCAFE, 1,0,1,0,32'h44,32'h0);
        add_vec(1,0,32'h44,0,0,32'h100,32'hDEADBEEF,FREE,32'h0,    0,0,0,0,32'h0,32'h0);
        // ERROR during DGRANT: no hit, back to IDLE, regrant, complete.
        add_vec(1,0,32'h0,1,0,32'h200,32'h0,FREE,32'h0,     0,0,0,0,32'h0,32'h0);
        add_vec(1,0,32'h0,1,0,32'h200,32'h0,ERROR,32'h0,    0,0,1,0,32'h200,32'h0);
        add_vec(1,0,32'h0,1,0,32'h200,32'h0,FREE,32'h0,     0,0,0,0,32'h0,32'h0);
        add_vec(1,0,32'h0,1,0,32'h200,32'h0,ACCESS,32'hABCD, 0,1,1,0,32'h200,32'h0);
        add_vec(1,0,32'h0,0,0,32'h200,32'h0,FREE,32'h0,     0,0,0,0,32'h0,32'h0);
        // dREN+dWEN: write wins; both withdrawn while granted -> abort, no hit.
        add_vec(1,0,32'h0,1,1,32'h300,32'h5A5A,FREE,32'h0,    0,0,0,0,32'h0,32'h0);
        add_vec(1,0,32'h0,1,1,32'h300,32'h5A5A,BUSY,32'h0,    0,0,0,1,32'h300,32'h5A5A);
        add_vec(1,0,32'h0,0,0,32'h300,32'h5A5A,ACCESS,32'h99, 0,0,0,0,32'h300,32'h5A5A);
        add_vec(1,0,32'h0,0,0,32'h300,32'h5A5A,FREE,32'h0,    0,0,0,0,32'h0,32'h0);
        // Async reset mid-IGRANT while BUSY, then the fetch restarts.
        add_vec(1,1,32'h80,0,0,32'h0,32'h0,FREE,32'h0,      0,0,0,0,32'h0,32'h0);
        add_vec(1,1,32'h80,0,0,32'h0,32'h0,BUSY,32'h0,      0,0,1,0,32'h80,32'h0);
        add_vec(0,1,32'h80,0,0,32'h0,32'h0,ACCESS,32'h42,   0,0,0,0,32'h0,32'h0);
        add_vec(1,1,32'h80,0,0,32'h0,32'h0,FREE,32'h0,      0,0,0,0,32'h0,32'h0);
        add_vec(1,1,32'h80,0,0,32'h0,32'h0,ACCESS,32'h42,   1,0,1,0,32'h80,32'h0);
        add_vec(1,0,32'h80,0,0,32'h0,32'h0,FREE,32'h0,      0,0,0,0,32'h0,32'h0);

        foreach (vecs[i]) begin
            @(negedge CLK);
            nRST = vecs[i].nrst; iREN = vecs[i].iren; iaddr = vecs[i].iaddr;
            dREN = vecs[i].dren; dWEN = vecs[i].dwen; daddr = vecs[i].daddr;
            dstore = vecs[i].dstore; ramstate = vecs[i].rs; ramload = vecs[i].rload;
            #2;
            nvec++;
            chk($sformatf("v%0d ihit", i),     32'(ihit),   32'(vecs[i].e_ihit));
            chk($sformatf("v%0d dhit", i),     32'(dhit),   32'(vecs[i].e_dhit));
            chk($sformatf("v%0d ramREN", i),   32'(ramREN), 32'(vecs[i].e_ren));
            chk($sformatf("v%0d ramWEN", i),   32'(ramWEN), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d ramaddr", i),  ramaddr,     vecs[i].e_addr);
            chk($sformatf("v%0d ramstore", i), ramstore,    vecs[i].e_store);
            chk($sformatf("v%0d iload", i),    iload, vecs[i].e_ihit ? vecs[i].rload : 32'h0);
            chk($sformatf("v%0d dload", i),    dload, vecs[i].e_dhit ? vecs[i].rload : 32'h0);
        end

        // Starvation: iREN held, data request always pending, RAM always ready.
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600; ramstate = ACCESS;
        nd   = 0;
        idx  = -1;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (ihit && dhit) begin
                nmis++;
                $display("FAIL starve coincident hits at cycle %0d", c);
            end
            if (dhit) nd++;
            if (ihit) begin
                done = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        nvec++;
        if (!done) begin
            nmis++;
            $display("FAIL starve timeout: no ihit within 40 cycles, dhits=%0d", nd);
        end
        chk("starve dhits before ihit", 32'(nd), 32'd4);
        @(negedge CLK);
        #2;
        nvec++;
        chk("starve_cnt after ihit", 32'(dut.starve_cnt), 32'd0);
        drive_idle();

        // Performance counters from a clean reset.
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        waits = 0;
        txn(1'b0, 1, 32'h1000, 32'h0A0A0001, waits);
        txn(1'b0, 1, 32'h1004, 32'h0A0A0002, waits);
        txn(1'b0, 1, 32'h1008, 32'h0A0A0003, waits);
        txn(1'b1, 2, 32'h2000, 32'h0B0B0001, waits);
        #2;
`ifdef MEM_ARBITER_PERF_CNT_EN
        exp_i = 32'd3;
        exp_d = 32'd1;
        exp_w = 32'(waits);
`else
        exp_i = 32'd0;
        exp_d = 32'd0;
        exp_w = 32'd0;
`endif
        nvec++;
        chk("perf_icnt", perf_icnt, exp_i);
        chk("perf_dcnt", perf_dcnt, exp_d);
        chk("perf_wait", perf_wait, exp_w);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
